// File: rtl/donut_raygen.sv
// donut_raygen: per-pixel ray generator feeding the donut ray-march hit tester.
// Latches camera/light operands on frame_start, walks the ray direction across
// each active line one slot every ITERS clocks, pulses start per slot and flags
// the clock at which each slot's hit tester result is ready (sample_valid).
// Optional build macro: RAYGEN_LINE_DOUBLE_EN -- row direction advances only
// on every second line_start so each ray row covers two scanlines.
module donut_raygen #(
  parameter int ITERS  = 8,
  parameter int SLOTS  = 80,
  parameter int SLOT_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [47:0]       org_in,
  input  logic [47:0]       corner_in,
  input  logic [47:0]       right_in,
  input  logic [47:0]       down_in,
  input  logic [47:0]       light_in,
  output logic              start,
  output logic [15:0]       px,
  output logic [15:0]       py,
  output logic [15:0]       pz,
  output logic [15:0]       rx,
  output logic [15:0]       ry,
  output logic [15:0]       rz,
  output logic [15:0]       lx,
  output logic [15:0]       ly,
  output logic [15:0]       lz,
  output logic              sample_valid,
  output logic [SLOT_W-1:0] sample_slot,
  output logic              busy
);

  localparam int                PH_W      = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(ITERS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Per-component 16-bit wrapping add of two {z,y,x} vectors.
  function automatic logic [47:0] vadd(input logic [47:0] a, input logic [47:0] b);
    logic [15:0] sx, sy, sz;
    sx = a[15:0]  + b[15:0];
    sy = a[31:16] + b[31:16];
    sz = a[47:32] + b[47:32];
    return {sz, sy, sx};
  endfunction

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [47:0]         org_q, org_d;
  logic [47:0]         right_q, right_d;
  logic [47:0]         down_q, down_d;
  logic [47:0]         light_q, light_d;
  logic [47:0]         row_dir_q, row_dir_d;
  logic [47:0]         ray_q, ray_d;
  logic                start_q, start_d;
  logic                sample_valid_q, sample_valid_d;
  logic [SLOT_W-1:0]   sample_slot_q, sample_slot_d;
`ifdef RAYGEN_LINE_DOUBLE_EN
  logic                parity_q, parity_d;
`endif

  // State register: every register resets synchronously to zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      slot_q         <= '0;
      org_q          <= '0;
      right_q        <= '0;
      down_q         <= '0;
      light_q        <= '0;
      row_dir_q      <= '0;
      ray_q          <= '0;
      start_q        <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_slot_q  <= '0;
`ifdef RAYGEN_LINE_DOUBLE_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      slot_q         <= slot_d;
      org_q          <= org_d;
      right_q        <= right_d;
      down_q         <= down_d;
      light_q        <= light_d;
      row_dir_q      <= row_dir_d;
      ray_q          <= ray_d;
      start_q        <= start_d;
      sample_valid_q <= sample_valid_d;
      sample_slot_q  <= sample_slot_d;
`ifdef RAYGEN_LINE_DOUBLE_EN
      parity_q       <= parity_d;
`endif
    end
  end

  // Next-state logic: frame_start beats line_start beats the RUN/DRAIN walk.
  // start/sample_valid are decoded from the next state so they appear as
  // registered outputs in the same cycle the state register reaches it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    phase_d        = phase_q;
    slot_d         = slot_q;
    org_d          = org_q;
    right_d        = right_q;
    down_d         = down_q;
    light_d        = light_q;
    row_dir_d      = row_dir_q;
    ray_d          = ray_q;
    start_d        = 1'b0;
    sample_valid_d = 1'b0;
    sample_slot_d  = sample_slot_q;
`ifdef RAYGEN_LINE_DOUBLE_EN
    parity_d       = parity_q;
`endif

    if (frame_start) begin
      org_d     = org_in;
      right_d   = right_in;
      down_d    = down_in;
      light_d   = light_in;
      row_dir_d = corner_in;
      phase_d   = '0;
      slot_d    = '0;
      state_d   = IDLE;
`ifdef RAYGEN_LINE_DOUBLE_EN
      parity_d  = 1'b0;
`endif
    end else if (line_start) begin
      // Any in-flight slot is dropped: its sample is simply never issued.
      ray_d   = row_dir_q;
`ifdef RAYGEN_LINE_DOUBLE_EN
      if (parity_q) row_dir_d = vadd(row_dir_q, down_q);
      parity_d = ~parity_q;
`else
      row_dir_d = vadd(row_dir_q, down_q);
`endif
      phase_d = '0;
      slot_d  = '0;
      state_d = RUN;
      start_d = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (phase_q == PH_LAST) begin
            // Result of the current slot is ready on the next clock.
            sample_valid_d = 1'b1;
            sample_slot_d  = slot_q;
            phase_d        = '0;
            if (slot_q == SLOT_LAST) begin
              state_d = DRAIN;
            end else begin
              ray_d   = vadd(ray_q, right_q);
              slot_d  = slot_q + SLOT_W'(1);
              start_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        DRAIN:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign start        = start_q;
  assign sample_valid = sample_valid_q;
  assign sample_slot  = sample_slot_q;
  assign busy         = (state_q != IDLE);
  assign {pz, py, px} = org_q;
  assign {rz, ry, rx} = ray_q;
  assign {lz, ly, lx} = light_q;

endmodule

// File: tb/tb_donut_raygen.sv
// Self-checking bench for donut_raygen (ITERS=8, SLOTS=4). Expected start
// pulses (cycle + ray) and samples (cycle + slot) are queued when a line is
// launched and compared by a monitor whenever the DUT asserts them.
module tb_donut_raygen;

  localparam int ITERS  = 8;
  localparam int SLOTS  = 4;
  localparam int SLOT_W = 7;

  typedef struct {
    int          cyc;
    logic [47:0] ray;
  } start_exp_t;

  typedef struct {
    int                cyc;
    logic [SLOT_W-1:0] slot;
  } sample_exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_start, line_start;
  logic [47:0]       org_in, corner_in, right_in, down_in, light_in;
  logic              start, sample_valid, busy;
  logic [15:0]       px, py, pz, rx, ry, rz, lx, ly, lz;
  logic [SLOT_W-1:0] sample_slot;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  start_exp_t  sq[$];
  sample_exp_t mq[$];

  // Reference model of the row walk.
  logic [47:0] m_row, m_right, m_down, m_org, m_light;
  logic        m_par;

  donut_raygen #(.ITERS(ITERS), .SLOTS(SLOTS), .SLOT_W(SLOT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .line_start   (line_start),
    .org_in       (org_in),
    .corner_in    (corner_in),
    .right_in     (right_in),
    .down_in      (down_in),
    .light_in     (light_in),
    .start        (start),
    .px           (px),
    .py           (py),
    .pz           (pz),
    .rx           (rx),
    .ry           (ry),
    .rz           (rz),
    .lx           (lx),
    .ly           (ly),
    .lz           (lz),
    .sample_valid (sample_valid),
    .sample_slot  (sample_slot),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [47:0] vec(input int x, input int y, input int z);
    logic [15:0] sx, sy, sz;
    sx = 16'(x);
    sy = 16'(y);
    sz = 16'(z);
    return {sz, sy, sx};
  endfunction

  function automatic logic [47:0] add3(input logic [47:0] a, input logic [47:0] b);
    int x, y, z;
    x = int'($signed(a[15:0]))  + int'($signed(b[15:0]));
    y = int'($signed(a[31:16])) + int'($signed(b[31:16]));
    z = int'($signed(a[47:32])) + int'($signed(b[47:32]));
    return vec(x, y, z);
  endfunction

  // Monitor: compare every start / sample against the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (start) begin
        checks++;
        assert (sq.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_start observed=1 expected=0 (cyc %0d)", cyc);
        end
        if (sq.size() != 0) begin
          start_exp_t e;
          e = sq.pop_front();
          check("start_cycle", 48'(cyc), 48'(e.cyc));
          check("ray", {rz, ry, rx}, e.ray);
        end
      end
      if (sample_valid) begin
        checks++;
        assert (mq.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_sample observed=1 expected=0 (cyc %0d)", cyc);
        end
        if (mq.size() != 0) begin
          sample_exp_t e;
          e = mq.pop_front();
          check("sample_cycle", 48'(cyc), 48'(e.cyc));
          check("sample_slot", 48'(sample_slot), 48'(e.slot));
        end
      end
    end
  end

  // Pulse frame_start with the given operands and update the model.
  task automatic do_frame(input logic [47:0] org, input logic [47:0] corner,
                          input logic [47:0] right, input logic [47:0] down,
                          input logic [47:0] light);
    org_in      = org;
    corner_in   = corner;
    right_in    = right;
    down_in     = down;
    light_in    = light;
    frame_start = 1'b1;
    m_org   = org;
    m_row   = corner;
    m_right = right;
    m_down  = down;
    m_light = light;
    m_par   = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Queue the expected starts/samples of a line, then pulse line_start.
  task automatic do_line(input int n_starts, input int n_samples);
    logic [47:0] ray;
    int          base;
    base = cyc;
    ray  = m_row;
`ifdef RAYGEN_LINE_DOUBLE_EN
    if (m_par) m_row = add3(m_row, m_down);
    m_par = ~m_par;
`else
    m_row = add3(m_row, m_down);
`endif
    for (int i = 0; i < n_starts; i++) begin
      sq.push_back('{cyc: base + 1 + ITERS * i, ray: ray});
      ray = add3(ray, m_right);
    end
    for (int i = 0; i < n_samples; i++)
      mq.push_back('{cyc: base + 1 + ITERS * (i + 1), slot: SLOT_W'(i)});
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Let a full line finish: DRAIN at +33, IDLE at +34 relative to line_start.
  task automatic finish_line(input string tag);
    repeat (ITERS * SLOTS) @(negedge clk);
    check({tag, "_busy_drain"}, 48'(busy), 48'd1);
    @(negedge clk);
    check({tag, "_busy_idle"}, 48'(busy), 48'd0);
    check({tag, "_start_q_empty"}, 48'(sq.size()), 48'd0);
    check({tag, "_sample_q_empty"}, 48'(mq.size()), 48'd0);
  endtask

  task automatic check_latched(input string tag);
    check({tag, "_org"}, {pz, py, px}, m_org);
    check({tag, "_light"}, {lz, ly, lx}, m_light);
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    org_in      = '0;
    corner_in   = '0;
    right_in    = '0;
    down_in     = '0;
    light_in    = '0;
    m_row = '0; m_right = '0; m_down = '0; m_org = '0; m_light = '0; m_par = 1'b0;

    // Reset held for three clocks.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_start", 48'(start), 48'd0);
    check("rst_sample_valid", 48'(sample_valid), 48'd0);
    check("rst_sample_slot", 48'(sample_slot), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_org", {pz, py, px}, 48'd0);
    check("rst_ray", {rz, ry, rx}, 48'd0);
    check("rst_light", {lz, ly, lx}, 48'd0);
    reset = 1'b0;
    @(negedge clk);

    // Line with no prior frame_start: zero operands, start timing only.
    do_line(SLOTS, SLOTS);
    finish_line("zero_line");

    // Frame with directed operands.
    do_frame(vec(11, 22, 33), vec(100, -50, 300), vec(2, 0, -1), vec(0, 3, 0),
             vec(7, -8, 9));
    check("frame_busy", 48'(busy), 48'd0);
    check_latched("frame");

    do_line(SLOTS, SLOTS);          // line A
    finish_line("line_a");
    do_line(SLOTS, SLOTS);          // line B
    finish_line("line_b");
    check_latched("after_b");

    // Line C aborted during slot 2 by line D.
    do_line(3, 2);
    repeat (2 * ITERS + 3) @(negedge clk);
    do_line(SLOTS, SLOTS);          // line D
    finish_line("line_d");

    // Line E interrupted by frame_start after slot 1 has started.
    do_line(2, 1);
    repeat (ITERS + 3) @(negedge clk);
    do_frame(vec(-1, 1000, -32768), vec(32767, 5, -7), vec(1, 0, 0), vec(0, 0, 0),
             vec(1, 2, 3));
    check("midline_frame_busy", 48'(busy), 48'd0);
    check("midline_frame_start", 48'(start), 48'd0);
    repeat (3 * ITERS) @(negedge clk);
    check("midline_start_q_empty", 48'(sq.size()), 48'd0);
    check("midline_sample_q_empty", 48'(mq.size()), 48'd0);
    check("midline_idle", 48'(busy), 48'd0);
    check_latched("new_frame");

    // Line F: x component wraps 32767 -> -32768.
    do_line(SLOTS, SLOTS);
    repeat (ITERS) @(negedge clk);
    check("wrap_rx", 48'(rx), 48'(16'h8000));
    check_latched("during_f");
    repeat (ITERS * SLOTS - ITERS) @(negedge clk);
    check("line_f_busy_drain", 48'(busy), 48'd1);
    @(negedge clk);
    check("line_f_busy_idle", 48'(busy), 48'd0);
    check_latched("after_f");

    repeat (4) @(negedge clk);
    check("final_start_q_empty", 48'(sq.size()), 48'd0);
    check("final_sample_q_empty", 48'(mq.size()), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
